// File: rtl/surf_cmd_pkg.sv
// Shared field map and run-command encoding for the CIN spliced command word.
// Imported by the SURF decoder and the TURFIO splice so both sides agree on bit positions.
package surf_cmd_pkg;

    localparam int unsigned CMD_PPS_BIT        = 31;
    localparam int unsigned CMD_RUNCMD_LSB     = 29;
    localparam int unsigned CMD_TRIG_VALID_BIT = 28;
    localparam int unsigned CMD_TRIG_LSB       = 13;
    localparam int unsigned CMD_FW_VALID_BIT   = 12;
    localparam int unsigned CMD_MARK_LSB       = 10;
    localparam int unsigned CMD_FW_LSB         = 2;
    localparam int unsigned CMD_PARITY_BIT     = 0;

    localparam int unsigned RUNCMD_W = 2;
    localparam int unsigned TRIG_W   = 15;
    localparam int unsigned MARK_W   = 2;
    localparam int unsigned FW_W     = 8;

    typedef enum logic [RUNCMD_W-1:0] {
        NOP   = 2'd0,
        SYNC  = 2'd1,
        START = 2'd2,
        STOP  = 2'd3
    } runcmd_e;

    // Even parity bit expected for a word whose bits [31:1] are given.
    function automatic logic cmd_parity(input logic [30:0] i_upper);
        return ^i_upper;
    endfunction

endpackage

// File: rtl/surf_cmd_decoder_if.sv
// AXI4-Stream bundle for the decoder's run-command, trigger and firmware outputs.
interface surf_cmd_decoder_if;
    import surf_cmd_pkg::*;

    logic [RUNCMD_W-1:0] runcmd_tdata;
    logic                runcmd_tvalid;
    logic                runcmd_tready;

    logic [TRIG_W-1:0]   trig_tdata;
    logic                trig_tvalid;
    logic                trig_tready;

    logic [FW_W-1:0]     fw_tdata;
    logic                fw_tlast;
    logic                fw_tvalid;
    logic                fw_tready;

    modport master (
        output runcmd_tdata, runcmd_tvalid,
        input  runcmd_tready,
        output trig_tdata, trig_tvalid,
        input  trig_tready,
        output fw_tdata, fw_tlast, fw_tvalid,
        input  fw_tready
    );

    modport slave (
        input  runcmd_tdata, runcmd_tvalid,
        output runcmd_tready,
        input  trig_tdata, trig_tvalid,
        output trig_tready,
        input  fw_tdata, fw_tlast, fw_tvalid,
        output fw_tready
    );

endinterface

// File: rtl/surf_cmd_fifo.sv
// First-word-fall-through FIFO with full/empty flags; DEPTH must be a power of 2, >= 2.
// Read data is forced to zero while empty so a reset also clears the visible tdata.
module surf_cmd_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 15
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_wr_en,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_rd_en,
    output logic [WIDTH-1:0] o_rd_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic             w_wr;
    logic             w_rd;

    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

    assign w_rd = i_rd_en && !o_empty;
    assign w_wr = i_wr_en && (!o_full || w_rd);

    assign o_rd_data = o_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge i_clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_wr_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
        end
    end

endmodule

// File: rtl/surf_cmd_decoder.sv
// SURF-side CIN command decoder: splits each spliced word into runcmd/trig/fw streams and PPS.
// Optional even-parity check on bit 0 is built when SURF_CMD_PARITY_EN is defined.
module surf_cmd_decoder #(
    parameter int unsigned TRIG_FIFO_DEPTH = 4,
    parameter int unsigned CNT_WIDTH       = 16
) (
    input  logic                 sysclk_i,
    input  logic                 rst_i,
    input  logic [31:0]          command_i,
    input  logic                 command_valid_i,
    input  logic                 command_locked_i,
    output logic [1:0]           m_runcmd_tdata,
    output logic                 m_runcmd_tvalid,
    input  logic                 m_runcmd_tready,
    output logic [14:0]          m_trig_tdata,
    output logic                 m_trig_tvalid,
    input  logic                 m_trig_tready,
    output logic [7:0]           m_fw_tdata,
    output logic                 m_fw_tlast,
    output logic                 m_fw_tvalid,
    input  logic                 m_fw_tready,
    output logic                 pps_o,
    output logic [CNT_WIDTH-1:0] trig_drop_count_o,
    output logic [CNT_WIDTH-1:0] fw_drop_count_o,
    output logic [CNT_WIDTH-1:0] parity_err_count_o
);

    import surf_cmd_pkg::*;

    localparam int unsigned FWE_W = MARK_W + FW_W;

    logic                 w_accept;
    logic                 w_pps;
    runcmd_e              w_runcmd;
    logic                 w_trig_req;
    logic [TRIG_W-1:0]    w_trig_time;
    logic                 w_fw_req;
    logic [MARK_W-1:0]    w_mark;
    logic [FW_W-1:0]      w_fw_byte;
    logic                 w_unused_bits;

    logic                 r_pps;
    logic [RUNCMD_W-1:0]  r_runcmd_tdata;
    logic                 r_runcmd_tvalid;
    logic [CNT_WIDTH-1:0] r_trig_drop_count;
    logic [CNT_WIDTH-1:0] r_fw_drop_count;

    logic                 w_trig_full;
    logic                 w_trig_empty;
    logic                 w_trig_pop;
    logic                 w_trig_wr;
    logic                 w_trig_drop;

    logic                 w_fw_full;
    logic                 w_fw_empty;
    logic                 w_fw_pop;
    logic                 w_fw_wr;
    logic                 w_fw_drop;
    logic [FWE_W-1:0]     w_fw_rd_data;

    assign w_pps       = command_i[CMD_PPS_BIT];
    assign w_runcmd    = runcmd_e'(command_i[CMD_RUNCMD_LSB +: RUNCMD_W]);
    assign w_trig_req  = command_i[CMD_TRIG_VALID_BIT];
    assign w_trig_time = command_i[CMD_TRIG_LSB +: TRIG_W];
    assign w_fw_req    = command_i[CMD_FW_VALID_BIT];
    assign w_mark      = command_i[CMD_MARK_LSB +: MARK_W];
    assign w_fw_byte   = command_i[CMD_FW_LSB +: FW_W];

`ifdef SURF_CMD_PARITY_EN
    logic                 w_parity_ok;
    logic                 w_parity_err;
    logic [CNT_WIDTH-1:0] r_parity_err_count;

    assign w_parity_ok  = (command_i[CMD_PARITY_BIT] ==
                           cmd_parity(command_i[CMD_PPS_BIT:CMD_PARITY_BIT+1]));
    assign w_accept     = command_valid_i && command_locked_i && w_parity_ok;
    assign w_parity_err = command_valid_i && command_locked_i && !w_parity_ok;

    always_ff @(posedge sysclk_i) begin
        if (rst_i) begin
            r_parity_err_count <= '0;
        end else if (w_parity_err && (r_parity_err_count != '1)) begin
            r_parity_err_count <= r_parity_err_count + CNT_WIDTH'(1);
        end
    end

    assign parity_err_count_o = r_parity_err_count;
    assign w_unused_bits      = ^{command_i[1], w_fw_rd_data[FWE_W-1]};
`else
    assign w_accept           = command_valid_i && command_locked_i;
    assign parity_err_count_o = '0;
    assign w_unused_bits      = ^{command_i[1], command_i[CMD_PARITY_BIT],
                                  w_fw_rd_data[FWE_W-1]};
`endif

    always_ff @(posedge sysclk_i) begin
        if (rst_i) begin
            r_pps <= 1'b0;
        end else begin
            r_pps <= w_accept && w_pps;
        end
    end

    // A fresh load beats a same-cycle handshake, so the newest command is never lost.
    always_ff @(posedge sysclk_i) begin
        if (rst_i) begin
            r_runcmd_tdata  <= '0;
            r_runcmd_tvalid <= 1'b0;
        end else if (w_accept && (w_runcmd != NOP)) begin
            r_runcmd_tdata  <= w_runcmd;
            r_runcmd_tvalid <= 1'b1;
        end else if (r_runcmd_tvalid && m_runcmd_tready) begin
            r_runcmd_tvalid <= 1'b0;
        end
    end

    assign w_trig_pop  = !w_trig_empty && m_trig_tready;
    assign w_trig_wr   = w_accept && w_trig_req && (!w_trig_full || w_trig_pop);
    assign w_trig_drop = w_accept && w_trig_req && w_trig_full && !w_trig_pop;

    surf_cmd_fifo #(
        .DEPTH (TRIG_FIFO_DEPTH),
        .WIDTH (TRIG_W)
    ) u_trig_fifo (
        .i_clk     (sysclk_i),
        .i_rst     (rst_i),
        .i_wr_en   (w_trig_wr),
        .i_wr_data (w_trig_time),
        .i_rd_en   (m_trig_tready),
        .o_rd_data (m_trig_tdata),
        .o_full    (w_trig_full),
        .o_empty   (w_trig_empty)
    );

    // Firmware skid buffer: a full buffer drops the byte even if a pop happens alongside.
    assign w_fw_pop  = !w_fw_empty && m_fw_tready;
    assign w_fw_wr   = w_accept && w_fw_req && !w_fw_full;
    assign w_fw_drop = w_accept && w_fw_req && w_fw_full;

    surf_cmd_fifo #(
        .DEPTH (2),
        .WIDTH (FWE_W)
    ) u_fw_skid (
        .i_clk     (sysclk_i),
        .i_rst     (rst_i),
        .i_wr_en   (w_fw_wr),
        .i_wr_data ({w_mark, w_fw_byte}),
        .i_rd_en   (w_fw_pop),
        .o_rd_data (w_fw_rd_data),
        .o_full    (w_fw_full),
        .o_empty   (w_fw_empty)
    );

    always_ff @(posedge sysclk_i) begin
        if (rst_i) begin
            r_trig_drop_count <= '0;
        end else if (w_trig_drop && (r_trig_drop_count != '1)) begin
            r_trig_drop_count <= r_trig_drop_count + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge sysclk_i) begin
        if (rst_i) begin
            r_fw_drop_count <= '0;
        end else if (w_fw_drop && (r_fw_drop_count != '1)) begin
            r_fw_drop_count <= r_fw_drop_count + CNT_WIDTH'(1);
        end
    end

    assign pps_o             = r_pps;
    assign m_runcmd_tdata    = r_runcmd_tdata;
    assign m_runcmd_tvalid   = r_runcmd_tvalid;
    assign m_trig_tvalid     = !w_trig_empty;
    assign m_fw_tdata        = w_fw_rd_data[FW_W-1:0];
    assign m_fw_tlast        = w_fw_rd_data[FW_W];
    assign m_fw_tvalid       = !w_fw_empty;
    assign trig_drop_count_o = r_trig_drop_count;
    assign fw_drop_count_o   = r_fw_drop_count;

endmodule

// File: tb/tb_surf_cmd_decoder.sv
// Directed bench for surf_cmd_decoder; the parity section follows SURF_CMD_PARITY_EN.
module tb_surf_cmd_decoder;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] cmd;
    logic        cmd_valid;
    logic        cmd_locked;
    logic        pps;
    logic [15:0] trig_drop;
    logic [15:0] fw_drop;
    logic [15:0] par_err;

    int checks   = 0;
    int failures = 0;

    surf_cmd_decoder_if u_if ();

    always #5 clk = ~clk;

    surf_cmd_decoder #(
        .TRIG_FIFO_DEPTH (4),
        .CNT_WIDTH       (16)
    ) dut (
        .sysclk_i           (clk),
        .rst_i              (rst),
        .command_i          (cmd),
        .command_valid_i    (cmd_valid),
        .command_locked_i   (cmd_locked),
        .m_runcmd_tdata     (u_if.runcmd_tdata),
        .m_runcmd_tvalid    (u_if.runcmd_tvalid),
        .m_runcmd_tready    (u_if.runcmd_tready),
        .m_trig_tdata       (u_if.trig_tdata),
        .m_trig_tvalid      (u_if.trig_tvalid),
        .m_trig_tready      (u_if.trig_tready),
        .m_fw_tdata         (u_if.fw_tdata),
        .m_fw_tlast         (u_if.fw_tlast),
        .m_fw_tvalid        (u_if.fw_tvalid),
        .m_fw_tready        (u_if.fw_tready),
        .pps_o              (pps),
        .trig_drop_count_o  (trig_drop),
        .fw_drop_count_o    (fw_drop),
        .parity_err_count_o (par_err)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] par(input logic [31:0] w);
        return {w[31:1], ^w[31:1]};
    endfunction

    function automatic logic [31:0] w_trig(input logic [14:0] t);
        return (32'd1 << 28) | ({17'd0, t} << 13);
    endfunction

    function automatic logic [31:0] w_fw(input logic [7:0] b, input logic [1:0] mark);
        return (32'd1 << 12) | ({30'd0, mark} << 10) | ({24'd0, b} << 2);
    endfunction

    function automatic logic [31:0] w_run(input logic [1:0] rc);
        return {rc, 30'd0} >> 1;
    endfunction

    initial begin
        rst = 1'b1; cmd = '0; cmd_valid = 1'b0; cmd_locked = 1'b1;
        u_if.runcmd_tready = 1'b0; u_if.trig_tready = 1'b0; u_if.fw_tready = 1'b0;
        step(); step();
        check("rst_pps", pps, 0);
        check("rst_run_valid", u_if.runcmd_tvalid, 0);
        check("rst_trig_valid", u_if.trig_tvalid, 0);
        check("rst_fw_valid", u_if.fw_tvalid, 0);
        check("rst_trig_drop", trig_drop, 0);
        rst = 1'b0;
        step();
        check("post_rst_trig_valid", u_if.trig_tvalid, 0);
        check("post_rst_run_data", u_if.runcmd_tdata, 0);

        // PPS: locked word gives one pulse, unlocked word gives none
        cmd = par(32'h8000_0000); cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
        check("pps_pulse", pps, 1);
        step();
        check("pps_single", pps, 0);
        cmd_locked = 1'b0; cmd_valid = 1'b1;
        step();
        check("pps_unlocked_a", pps, 0);
        cmd_valid = 1'b0;
        step();
        check("pps_unlocked_b", pps, 0);
        cmd_locked = 1'b1;

        // Trigger FIFO: six writes into depth four, then drain
        cmd = par(w_trig(15'd1)); cmd_valid = 1'b1;
        step();
        check("trig_first_valid", u_if.trig_tvalid, 1);
        check("trig_first_data", u_if.trig_tdata, 15'd1);
        for (int i = 2; i <= 6; i++) begin
            cmd = par(w_trig(15'(i)));
            step();
        end
        cmd_valid = 1'b0;
        check("trig_drop_two", trig_drop, 2);
        check("trig_head_held", u_if.trig_tdata, 15'd1);
        u_if.trig_tready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            check("trig_drain_valid", u_if.trig_tvalid, 1);
            check("trig_drain_data", u_if.trig_tdata, 32'(k));
            step();
        end
        check("trig_drained", u_if.trig_tvalid, 0);
        u_if.trig_tready = 1'b0;

        // Runcmd: START then STOP collapses to one STOP beat
        cmd = par(w_run(2'd2)); cmd_valid = 1'b1;
        step();
        cmd = par(w_run(2'd3));
        step();
        cmd_valid = 1'b0;
        check("run_valid", u_if.runcmd_tvalid, 1);
        check("run_newest", u_if.runcmd_tdata, 2'd3);
        step();
        check("run_held", u_if.runcmd_tdata, 2'd3);
        u_if.runcmd_tready = 1'b1;
        step();
        check("run_cleared", u_if.runcmd_tvalid, 0);
        cmd = par(w_run(2'd1)); cmd_valid = 1'b1;
        step();
        check("run_sync", u_if.runcmd_tdata, 2'd1);
        cmd = par(w_run(2'd3));
        step();
        cmd_valid = 1'b0;
        check("run_load_beats_hs_valid", u_if.runcmd_tvalid, 1);
        check("run_load_beats_hs_data", u_if.runcmd_tdata, 2'd3);
        step();
        check("run_final_clear", u_if.runcmd_tvalid, 0);
        u_if.runcmd_tready = 1'b0;

        // Firmware: two streamed bytes, last one marked
        u_if.fw_tready = 1'b1;
        cmd = par(w_fw(8'hA5, 2'b00)); cmd_valid = 1'b1;
        step();
        check("fw0_valid", u_if.fw_tvalid, 1);
        check("fw0_data", u_if.fw_tdata, 8'hA5);
        check("fw0_last", u_if.fw_tlast, 0);
        cmd = par(w_fw(8'h5A, 2'b01));
        step();
        cmd_valid = 1'b0;
        check("fw1_data", u_if.fw_tdata, 8'h5A);
        check("fw1_last", u_if.fw_tlast, 1);
        step();
        check("fw_empty", u_if.fw_tvalid, 0);
        check("fw_no_drop", fw_drop, 0);

        // Firmware: third byte into a full skid buffer is dropped
        u_if.fw_tready = 1'b0;
        cmd = par(w_fw(8'h11, 2'b10)); cmd_valid = 1'b1;
        step();
        cmd = par(w_fw(8'h22, 2'b00));
        step();
        cmd = par(w_fw(8'h33, 2'b01));
        step();
        cmd_valid = 1'b0;
        check("fw_drop_one", fw_drop, 1);
        u_if.fw_tready = 1'b1;
        check("fw_skid0", u_if.fw_tdata, 8'h11);
        check("fw_skid0_last", u_if.fw_tlast, 0);
        step();
        check("fw_skid1", u_if.fw_tdata, 8'h22);
        step();
        check("fw_skid_empty", u_if.fw_tvalid, 0);
        u_if.fw_tready = 1'b0;

        // Lock loss: buffered trigger drains, unlocked word ignored
        cmd = par(w_trig(15'h55)); cmd_valid = 1'b1;
        step();
        cmd_locked = 1'b0; cmd = par(w_trig(15'h66));
        step();
        cmd_valid = 1'b0;
        u_if.trig_tready = 1'b1;
        check("lock_drain_data", u_if.trig_tdata, 15'h55);
        step();
        check("lock_ignored", u_if.trig_tvalid, 0);
        cmd_locked = 1'b1; u_if.trig_tready = 1'b0;

        // Reset with buffered traffic
        cmd = par(w_trig(15'd7) | w_run(2'd1) | (32'd1 << 31)); cmd_valid = 1'b1;
        step();
        cmd = par(w_trig(15'd8));
        step();
        cmd = par(w_trig(15'd9));
        step();
        cmd_valid = 1'b0;
        check("pre_rst_trig_data", u_if.trig_tdata, 15'd7);
        rst = 1'b1;
        step();
        check("mid_rst_trig_valid", u_if.trig_tvalid, 0);
        check("mid_rst_trig_data", u_if.trig_tdata, 0);
        check("mid_rst_run_valid", u_if.runcmd_tvalid, 0);
        check("mid_rst_fw_valid", u_if.fw_tvalid, 0);
        check("mid_rst_trig_drop", trig_drop, 0);
        check("mid_rst_fw_drop", fw_drop, 0);
        rst = 1'b0;
        step();
        check("after_rst_trig_valid", u_if.trig_tvalid, 0);

`ifdef SURF_CMD_PARITY_EN
        cmd = 32'h9000_2000; cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
        check("par_bad_pps", pps, 0);
        check("par_bad_trig", u_if.trig_tvalid, 0);
        check("par_err_count", par_err, 1);
        cmd = 32'h9000_2001; cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
        check("par_good_pps", pps, 1);
        check("par_good_trig_valid", u_if.trig_tvalid, 1);
        check("par_good_trig_data", u_if.trig_tdata, 15'd1);
        check("par_err_stable", par_err, 1);
`else
        cmd = 32'h9000_2000; cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
        check("nopar_pps", pps, 1);
        check("nopar_trig_valid", u_if.trig_tvalid, 1);
        check("nopar_trig_data", u_if.trig_tdata, 15'd1);
        check("nopar_err_zero", par_err, 0);
`endif
        u_if.trig_tready = 1'b1;
        step();
        check("final_pps_low", pps, 0);
        check("final_trig_empty", u_if.trig_tvalid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
